// File: rtl/i_memory.sv
// LEGv8 MEM stage: EX/MEM stage register, branch resolution and a multi-cycle
// data RAM whose in-flight accesses stall the upstream pipeline.
//
// state | meaning
// IDLE  | no access in flight; stage register follows EX every cycle
// BUSY  | load/store waiting on the RAM; stage register frozen, mem_stall high
module i_memory #(
    parameter int WORD        = 64,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [WORD-1:0] branch_target_in,
    input  logic [WORD-1:0] alu_result_in,
    input  logic            zero_in,
    input  logic [WORD-1:0] read_data2_in,
    input  logic [4:0]      write_register_in,
    input  logic            uncondbranch_in,
    input  logic            branch_in,
    input  logic            mem_read_in,
    input  logic            mem_write_in,
    input  logic            mem_to_reg_in,
    input  logic            reg_write_in,
    output logic            pc_src,
    output logic [WORD-1:0] branch_target,
    output logic [WORD-1:0] alu_result,
    output logic [WORD-1:0] read_data,
    output logic [4:0]      write_register,
    output logic            mem_to_reg,
    output logic            reg_write,
    output logic            mem_stall,
    output logic            addr_err
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [2:0] WAIT_CNT = 3'(WAIT_CYCLES);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state, state_next;
    logic [2:0]      cnt, cnt_next;
    logic            commit;

    logic            uncondbranch_q, branch_q, zero_q;
    logic            mem_read_q, mem_write_q, reg_write_q;
    logic [WORD-1:0] read_data2_q;

    logic [WORD-1:0] ram [DEPTH];
    logic [AW-1:0]   index;
    logic            in_range;

    // Stage register: frozen while an access is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_target  <= '0;
            alu_result     <= '0;
            zero_q         <= 1'b0;
            read_data2_q   <= '0;
            write_register <= '0;
            uncondbranch_q <= 1'b0;
            branch_q       <= 1'b0;
            mem_read_q     <= 1'b0;
            mem_write_q    <= 1'b0;
            mem_to_reg     <= 1'b0;
            reg_write_q    <= 1'b0;
        end else if (!mem_stall) begin
            branch_target  <= branch_target_in;
            alu_result     <= alu_result_in;
            zero_q         <= zero_in;
            read_data2_q   <= read_data2_in;
            write_register <= write_register_in;
            uncondbranch_q <= uncondbranch_in;
            branch_q       <= branch_in;
            mem_read_q     <= mem_read_in;
            mem_write_q    <= mem_write_in;
            mem_to_reg     <= mem_to_reg_in;
            reg_write_q    <= reg_write_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // In IDLE the stage register always loads, so a new memory op starts here.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (mem_read_in || mem_write_in) begin
                    state_next = BUSY;
                    cnt_next   = WAIT_CNT;
                end
            end
            BUSY: begin
                cnt_next = cnt - 3'd1;
                if (cnt == 3'd1) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        mem_stall = (state == BUSY);
        commit    = (state == BUSY) && (cnt == 3'd1);
    end

    assign index     = alu_result[AW+2:3];
    assign in_range  = ~|alu_result[WORD-1:AW+3];
    assign pc_src    = uncondbranch_q | (branch_q & zero_q);
    assign reg_write = reg_write_q & ~mem_stall;

    always_ff @(posedge clk) begin
        if (commit && mem_write_q && in_range) begin
            ram[index] <= read_data2_q;
        end
    end

    // Nonblocking read of ram gives pre-write data when read and write coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_data <= '0;
            addr_err  <= 1'b0;
        end else begin
            addr_err <= commit & ~in_range;
            if (commit && mem_read_q) begin
                read_data <= in_range ? ram[index] : '0;
            end
        end
    end

endmodule
